// File: rtl/px_write_fifo.sv
// px_write_fifo: elastic buffer between the game FSM pixel-write port and the
// frame-buffer write port. Writes are queued in order and drained one per
// cycle while fb_ready is high; frame-buffer outputs are registered.
// Optional feature macro: PX_CLIP_EN -- when defined, writes whose address is
// >= PX_MAX are discarded at the input instead of being queued.
module px_write_fifo #(
  parameter int AW     = 19,
  parameter int DW     = 12,
  parameter int DEPTH  = 16,
  parameter int PX_MAX = 307200
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [AW-1:0]            in_px_addr,
  input  logic [DW-1:0]            in_px_data,
  input  logic                     in_px_wr,
  output logic                     in_full,
  input  logic                     fb_ready,
  output logic [AW-1:0]            mem_px_addr,
  output logic [DW-1:0]            mem_px_data,
  output logic                     px_wr,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int EW = AW + DW;

  localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
  localparam logic [AW:0]   PX_MAX_L = (AW+1)'(PX_MAX);

  // Storage: one entry holds {address, data}; contents need no reset since
  // only entries between the pointers are ever read out.
  logic [EW-1:0] mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;
  logic          px_wr_q, px_wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;

  logic          accept;
  logic          push;
  logic          pop;
  logic          drop;
  logic [EW-1:0] head;

`ifdef PX_CLIP_EN
  // Off-screen writes never enter the queue and do not count as overflow.
  assign accept = in_px_wr && ({1'b0, in_px_addr} < PX_MAX_L);
`else
  // Every write is a candidate; the range compare exists only to keep
  // PX_MAX referenced in builds where clipping is off.
  logic unused_px_max;
  assign unused_px_max = ({1'b0, in_px_addr} < PX_MAX_L);
  assign accept        = in_px_wr;
`endif

  // Pop is decided from the registered level, so an entry pushed into an
  // empty queue cannot fall through in the same cycle. A push into a full
  // queue is still allowed when a pop frees a slot on the same edge.
  assign in_full = (level_q == DEPTH_L);
  assign pop     = fb_ready && (level_q != '0);
  assign push    = accept && (!in_full || pop);
  assign drop    = accept && !push;
  assign head    = mem_q[rd_ptr_q];

  // Next-state computation for pointers, occupancy and output registers.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    px_wr_d    = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      px_wr_d  = 1'b1;
      addr_d   = head[EW-1:DW];
      data_d   = head[DW-1:0];
    end

    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    if (drop) begin
      overflow_d = 1'b1;
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      px_wr_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      px_wr_q    <= px_wr_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

  // Storage write port; a write during reset is harmless because the
  // pointers are cleared on the same edge.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_px_addr, in_px_data};
    end
  end

  assign mem_px_addr = addr_q;
  assign mem_px_data = data_q;
  assign px_wr       = px_wr_q;
  assign level       = level_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_px_write_fifo.sv
// Testbench for px_write_fifo: directed scenarios plus randomized traffic,
// all checked against a queue-based reference model of the buffer.
module tb_px_write_fifo;

  localparam int AW = 19;
  localparam int DW = 12;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] in_px_addr = '0;
  logic [DW-1:0] in_px_data = '0;
  logic          in_px_wr = 1'b0;
  logic          in_full;
  logic          fb_ready = 1'b0;
  logic [AW-1:0] mem_px_addr;
  logic [DW-1:0] mem_px_data;
  logic          px_wr;
  logic [4:0]    level;
  logic          overflow;

  int total = 0;
  int bad = 0;

  // Reference model state
  logic [AW+DW-1:0] m_q[$];
  logic             m_px_wr = 1'b0;
  logic [AW-1:0]    m_addr = '0;
  logic [DW-1:0]    m_data = '0;
  logic             m_ovf = 1'b0;

  px_write_fifo #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .PX_MAX(307200)) dut (
    .clk(clk), .rst(rst),
    .in_px_addr(in_px_addr), .in_px_data(in_px_data), .in_px_wr(in_px_wr),
    .in_full(in_full), .fb_ready(fb_ready),
    .mem_px_addr(mem_px_addr), .mem_px_data(mem_px_data), .px_wr(px_wr),
    .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, advance the model by the buffer's rules, then
  // wait for the clock edge and settle 1ns past it.
  task automatic step(input bit r, input bit wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input bit rdy);
    bit clip, acc, do_pop, do_push;
    logic [AW+DW-1:0] e;
    rst = r; in_px_wr = wr; in_px_addr = a; in_px_data = d; fb_ready = rdy;
    if (r) begin
      m_q.delete(); m_px_wr = 0; m_addr = '0; m_data = '0; m_ovf = 0;
    end else begin
`ifdef PX_CLIP_EN
      clip = (a >= 19'd307200);
`else
      clip = 0;
`endif
      acc = wr && !clip;
      do_pop = rdy && (m_q.size() != 0);
      do_push = acc && (m_q.size() < DEPTH || do_pop);
      if (acc && !do_push) m_ovf = 1;
      if (do_pop) begin
        e = m_q.pop_front();
        m_px_wr = 1; m_addr = e[AW+DW-1:DW]; m_data = e[DW-1:0];
        $display("px out t=%0t addr=%0d data=%03h", $time, m_addr, m_data);
      end else begin
        m_px_wr = 0;
      end
      if (do_push) m_q.push_back({a, d});
    end
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic test_reset();
    step(1, 0, '0, '0, 0);
    total++; if (level !== 5'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
    total++; if (px_wr !== 1'b0) begin bad++; $display("FAIL reset_px_wr got=%b exp=0", px_wr); end
    total++; if (in_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", in_full); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    total++; if (mem_px_addr !== '0 || mem_px_data !== '0) begin bad++;
      $display("FAIL reset_outs got=%0d/%03h exp=0/000", mem_px_addr, mem_px_data); end
  endtask

  task automatic test_single();
    step(1, 0, '0, '0, 1);
    step(0, 1, 19'd100, 12'hF00, 1);
    total++; if (px_wr !== 1'b0 || level !== 5'd1) begin bad++;
      $display("FAIL single_lat1 got px_wr=%b level=%0d exp 0/1", px_wr, level); end
    step(0, 0, '0, '0, 1);
    total++; if (px_wr !== 1'b1 || mem_px_addr !== 19'd100 || mem_px_data !== 12'hF00) begin bad++;
      $display("FAIL single_out got=%b %0d %03h exp=1 100 F00", px_wr, mem_px_addr, mem_px_data); end
    step(0, 0, '0, '0, 1);
    total++; if (px_wr !== 1'b0 || level !== 5'd0) begin bad++;
      $display("FAIL single_after got px_wr=%b level=%0d exp 0/0", px_wr, level); end
  endtask

  task automatic test_fill_overflow();
    step(1, 0, '0, '0, 0);
    for (int i = 0; i < 16; i++) step(0, 1, AW'(i), DW'(i + 32), 0);
    total++; if (level !== 5'd16 || in_full !== 1'b1 || overflow !== 1'b0) begin bad++;
      $display("FAIL fill got level=%0d full=%b ovf=%b exp 16/1/0", level, in_full, overflow); end
    step(0, 1, 19'd999, 12'h123, 0);
    total++; if (overflow !== 1'b1 || level !== 5'd16) begin bad++;
      $display("FAIL drop got ovf=%b level=%0d exp 1/16", overflow, level); end
    for (int i = 0; i < 16; i++) begin
      step(0, 0, '0, '0, 1);
      total++; if (px_wr !== 1'b1 || mem_px_addr !== AW'(i) || mem_px_data !== DW'(i + 32)) begin bad++;
        $display("FAIL drain%0d got=%b %0d %03h exp=1 %0d %03h", i, px_wr, mem_px_addr,
                 mem_px_data, i, i + 32); end
    end
    step(0, 0, '0, '0, 1);
    total++; if (px_wr !== 1'b0 || overflow !== 1'b1 || level !== 5'd0) begin bad++;
      $display("FAIL drain_end got px_wr=%b ovf=%b level=%0d exp 0/1/0", px_wr, overflow, level); end
  endtask

  task automatic test_full_pushpop();
    step(1, 0, '0, '0, 0);
    for (int i = 0; i < 16; i++) step(0, 1, AW'(i), DW'(i), 0);
    step(0, 1, 19'd500, 12'h5A5, 1);
    total++; if (level !== 5'd16 || overflow !== 1'b0 || px_wr !== 1'b1 || mem_px_addr !== 19'd0) begin bad++;
      $display("FAIL full_pp got level=%0d ovf=%b px_wr=%b addr=%0d exp 16/0/1/0",
               level, overflow, px_wr, mem_px_addr); end
    for (int i = 1; i < 16; i++) begin
      step(0, 0, '0, '0, 1);
      total++; if (px_wr !== 1'b1 || mem_px_addr !== AW'(i)) begin bad++;
        $display("FAIL full_pp_seq%0d got=%b %0d exp=1 %0d", i, px_wr, mem_px_addr, i); end
    end
    step(0, 0, '0, '0, 1);
    total++; if (px_wr !== 1'b1 || mem_px_addr !== 19'd500 || mem_px_data !== 12'h5A5) begin bad++;
      $display("FAIL full_pp_last got=%b %0d %03h exp=1 500 5A5", px_wr, mem_px_addr, mem_px_data); end
  endtask

  task automatic test_toggle();
    int nxt;
    bit rdy;
    nxt = 0;
    step(1, 0, '0, '0, 0);
    for (int c = 0; c < 40; c++) begin
      rdy = (c % 2 == 0);
      if (c < 8) step(0, 1, AW'(c), DW'(c * 3), rdy);
      else step(0, 0, '0, '0, rdy);
      total++; if (px_wr !== m_px_wr) begin bad++;
        $display("FAIL toggle_pxwr c=%0d got=%b exp=%b", c, px_wr, m_px_wr); end
      if (px_wr === 1'b1) begin
        total++; if (mem_px_addr !== AW'(nxt) || !rdy) begin bad++;
          $display("FAIL toggle_order c=%0d got=%0d exp=%0d rdy=%b", c, mem_px_addr, nxt, rdy); end
        nxt++;
      end
    end
    total++; if (nxt !== 8) begin bad++; $display("FAIL toggle_count got=%0d exp=8", nxt); end
  endtask

  task automatic test_reset_mid();
    step(1, 0, '0, '0, 0);
    for (int i = 0; i < 17; i++) step(0, 1, AW'(i + 40), 12'hABC, 0);
    step(1, 0, '0, '0, 1);
    total++; if (level !== 5'd0 || px_wr !== 1'b0 || overflow !== 1'b0) begin bad++;
      $display("FAIL rst_mid got level=%0d px_wr=%b ovf=%b exp 0/0/0", level, px_wr, overflow); end
    for (int i = 0; i < 10; i++) begin
      step(0, 0, '0, '0, 1);
      total++; if (px_wr !== 1'b0) begin bad++; $display("FAIL rst_stale%0d got px_wr=1 exp=0", i); end
    end
  endtask

  task automatic test_clip();
    logic [AW-1:0] seen[$];
    step(1, 0, '0, '0, 1);
    step(0, 1, 19'd307200, 12'h111, 1);
    step(0, 1, 19'd307199, 12'h222, 1);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, '0, '0, 1);
      if (px_wr === 1'b1) seen.push_back(mem_px_addr);
    end
    // The second sample after the first write is the first possible output.
`ifdef PX_CLIP_EN
    total++; if (seen.size() !== 1 || seen[0] !== 19'd307199) begin bad++;
      $display("FAIL clip got n=%0d first=%0d exp n=1 first=307199", seen.size(),
               seen.size() ? seen[0] : 0); end
`else
    total++; if (seen.size() !== 1 || seen[0] !== 19'd307199) begin bad++;
      $display("FAIL clip_tail got n=%0d first=%0d exp n=1 first=307199", seen.size(),
               seen.size() ? seen[0] : 0); end
`endif
  endtask

  task automatic test_clip_order();
    logic [AW-1:0] seen[$];
    step(1, 0, '0, '0, 1);
    step(0, 1, 19'd307200, 12'h111, 1);
    if (px_wr === 1'b1) seen.push_back(mem_px_addr);
    step(0, 1, 19'd307199, 12'h222, 1);
    if (px_wr === 1'b1) seen.push_back(mem_px_addr);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, '0, '0, 1);
      if (px_wr === 1'b1) seen.push_back(mem_px_addr);
    end
`ifdef PX_CLIP_EN
    total++; if (seen.size() !== 1 || seen[0] !== 19'd307199) begin bad++;
      $display("FAIL clip_order got n=%0d exp n=1 addr 307199", seen.size()); end
`else
    total++; if (seen.size() !== 2 || seen[0] !== 19'd307200 || seen[1] !== 19'd307199) begin bad++;
      $display("FAIL clip_order got n=%0d exp n=2 addrs 307200,307199", seen.size()); end
`endif
  endtask

  task automatic test_random();
    bit r, wr, rdy;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    step(1, 0, '0, '0, 0);
    for (int c = 0; c < 600; c++) begin
      r   = ($urandom_range(0, 99) == 0);
      wr  = ($urandom_range(0, 99) < 60);
      rdy = ($urandom_range(0, 99) < ((c / 100) % 2 ? 75 : 35));
      a   = AW'($urandom_range(0, 524287));
      d   = DW'($urandom);
      step(r, wr, a, d, rdy);
      total++; if (px_wr !== m_px_wr || level !== 5'(m_q.size()) || in_full !== (m_q.size() == DEPTH)
                   || overflow !== m_ovf || mem_px_addr !== m_addr || mem_px_data !== m_data) begin
        bad++;
        $display("FAIL rand c=%0d got wr=%b lv=%0d f=%b ov=%b a=%0d d=%03h exp wr=%b lv=%0d f=%b ov=%b a=%0d d=%03h",
                 c, px_wr, level, in_full, overflow, mem_px_addr, mem_px_data,
                 m_px_wr, m_q.size(), m_q.size() == DEPTH, m_ovf, m_addr, m_data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_full_pushpop();
    test_toggle();
    test_reset_mid();
    test_clip();
    test_clip_order();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
